ahb_lite_mem_bridge: RTL
========================

// Module: ahb_lite_mem_bridge
// PURPOSE
// Parametrised AHB-Lite slave bridging one AHB-Lite port to a single-port memory req/grant interface.
// Adds address-window decode, byte strobes from HSIZE/HADDR, and alignment/size checks.
// Adds a grant-timeout error and correct pipelined back-to-back transfers.
// Sits between the AHB-Lite interconnect and a memory controller or arbiter.
// PARAMETERS
// ADDR_WIDTH      32    HADDR / memory address width
// DATA_WIDTH      32    HWDATA/HRDATA width; power of two, 8..128
// BASE_ADDR       0     first byte address of the slave window
// MEM_BYTES       4096  window size in bytes; valid range is [BASE_ADDR, BASE_ADDR+MEM_BYTES)
// TIMEOUT_CYCLES  16    max REQ cycles without GRANT before ERROR; 0 disables the timeout
// PORTS
// HCLK          in   1           clock
// HRESETn       in   1           asynchronous active-low reset
// HSEL_slv_i    in   1           slave select
// HADDR_slv_i   in   ADDR_WIDTH  address-phase address
// HSIZE_slv_i   in   3           transfer size
// HBURST_slv_i  in   3           burst type; ignored, since the master supplies every address
// HTRANS_slv_i  in   2           IDLE/BUSY/NONSEQ/SEQ
// HWRITE_slv_i  in   1           1 = write
// HREADY_slv_i  in   1           bus HREADY; address phase is valid only when this is 1
// HWDATA_slv_i  in   DATA_WIDTH  write data
// HREADY_slv_o  out  1           HREADYOUT
// HRESP_slv_o   out  1           0 = OKAY, 1 = ERROR
// HRDATA_slv_o  out  DATA_WIDTH  read data
// ADDR_slv_o    out  ADDR_WIDTH  memory byte address, offset from BASE_ADDR
// WRITE_slv_o   out  1           memory write
// WDATA_slv_o   out  DATA_WIDTH  memory write data
// BE_slv_o      out  DATA_WIDTH/8  byte enables
// REQ_slv_o     out  1           memory request
// GRANT_slv_i   in   1           memory accepts the request; RDATA is valid in the same cycle
// RDATA_slv_i   in   DATA_WIDTH  memory read data
// BEHAVIOUR
// - All outputs are registered.
//   Reset values: HREADY_slv_o=1; every other output 0; state IDLE; timeout counter 0.
// - Reset is asynchronous at any point: REQ drops immediately and any in-flight transfer is abandoned.
// - Transfer accepted on a clock edge where all hold: HSEL=1, HREADY_slv_i=1, HTRANS in {NONSEQ,SEQ}.
//   Acceptance is evaluated only in states IDLE, RESP and ERR2.
//   BUSY and IDLE transfers get a zero-wait OKAY.
// - HSEL is sampled only in the address phase; once accepted, a transfer always completes.
// - Error check on acceptance (first matching rule wins):
//   1. address outside the window;
//   2. HSIZE > log2(DATA_WIDTH/8);
//   3. HADDR not aligned to 2^HSIZE.
//   Any error -> ERR1, and no memory access is made.
// - BE: 2^HSIZE consecutive ones, starting at lane HADDR[log2(DATA_WIDTH/8)-1:0].
// - States:
//   IDLE  HREADY=1, HRESP=0, REQ=0. Accepted write -> WDATA; accepted read -> MREQ,
//         latching ADDR/BE with WRITE=0.
//   WDATA HREADY=0. Latch ADDR/BE/WRITE=1 from the address phase; sample HWDATA -> WDATA_slv_o.
//         Next state MREQ.
//   MREQ  REQ=1, HREADY=0. ADDR/WDATA/BE/WRITE held stable.
//         GRANT=1 -> RESP; on a read, HRDATA <= RDATA.
//         Otherwise the counter increments; at TIMEOUT_CYCLES -> ERR1 with REQ deasserted.
//         GRANT and timeout in the same cycle: GRANT wins.
//   RESP  HREADY=1, HRESP=0 for one cycle. Pipelined accept as in IDLE, otherwise -> IDLE.
//   ERR1  HREADY=0, HRESP=1, REQ=0. Next state ERR2.
//   ERR2  HREADY=1, HRESP=1. Accept as in IDLE (the master may also cancel with HTRANS=IDLE).
// - Latency, counted from address phase at edge N with GRANT asserted immediately:
//   read  HREADY=1 with data at N+2 (1 wait state);
//   write completes at N+3 (2 wait states).
// - The timeout counter clears on entry to MREQ. Width: clog2(TIMEOUT_CYCLES+1).
// - ADDR_slv_o = HADDR - BASE_ADDR, truncated to ADDR_WIDTH.
// STRUCTURE
// - Package ahb_lite_pkg holds:
//   HTRANS codes (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3);
//   HRESP codes (OKAY=0, ERROR=1);
//   HSIZE codes;
//   the state encoding (IDLE, WDATA, MREQ, RESP, ERR1, ERR2).
// - Sub-module ahb_lite_xfer_check: purely combinational; computes range/size/alignment error
//   and BE from HADDR/HSIZE.
// - The top level keeps the FSM, the timeout counter and the output registers.
// TESTING
// 1. Read at 0x10, GRANT held 1 -> REQ=1 at N+1, HREADY_slv_o=1 at N+2, HRDATA=RDATA (0xDEADBEEF), HRESP=0.
// 2. Byte write 0xAB at 0x13, HSIZE=0 -> BE=4'b1000, WRITE=1, ADDR=0x13, REQ until GRANT, OKAY.
// 3. Halfword read at 0x11, or addr BASE_ADDR+MEM_BYTES -> REQ stays 0; HREADY 0 then 1 with HRESP=1 both cycles.
// 4. GRANT held 0, TIMEOUT_CYCLES=16 -> REQ high exactly 16 cycles, then two-cycle ERROR; GRANT on cycle 16 -> OKAY.
// 5. 4-beat INCR write burst, SEQ pipelined in RESP -> 4 memory writes, addresses 0x20..0x2C, correct WDATA order.
// 6. HRESETn low while in MREQ -> REQ=0 and HREADY_slv_o=1 immediately; next transfer after release completes OKAY.

Source files
------------

// File: rtl/ahb_lite_mem_bridge_pkg.sv
// Shared encodings for the AHB-Lite to memory bridge: bus codes, FSM states,
// and the transfer-check error classes.
package ahb_lite_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_e;

   localparam logic [2:0] HSIZE_BYTE   = 3'd0;
   localparam logic [2:0] HSIZE_HALF   = 3'd1;
   localparam logic [2:0] HSIZE_WORD   = 3'd2;
   localparam logic [2:0] HSIZE_DWORD  = 3'd3;
   localparam logic [2:0] HSIZE_4WORD  = 3'd4;
   localparam logic [2:0] HSIZE_8WORD  = 3'd5;
   localparam logic [2:0] HSIZE_16WORD = 3'd6;
   localparam logic [2:0] HSIZE_32WORD = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WDATA = 3'd1,
      ST_MREQ  = 3'd2,
      ST_RESP  = 3'd3,
      ST_ERR1  = 3'd4,
      ST_ERR2  = 3'd5
   } bridge_state_e;

   // Error classes in priority order: range beats size beats alignment.
   typedef enum logic [1:0] {
      XERR_NONE  = 2'd0,
      XERR_RANGE = 2'd1,
      XERR_SIZE  = 2'd2,
      XERR_ALIGN = 2'd3
   } xfer_err_e;

endpackage

// File: rtl/ahb_lite_mem_bridge_if.sv
// AHB-Lite slave port plus memory req/grant port of the bridge, bundled.
// The slave modport is the bridge's view; master is the bus/memory side.
interface ahb_lite_mem_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    HSEL_slv_i;
   logic [ADDR_WIDTH-1:0]   HADDR_slv_i;
   logic [2:0]              HSIZE_slv_i;
   logic [2:0]              HBURST_slv_i;
   logic [1:0]              HTRANS_slv_i;
   logic                    HWRITE_slv_i;
   logic                    HREADY_slv_i;
   logic [DATA_WIDTH-1:0]   HWDATA_slv_i;
   logic                    HREADY_slv_o;
   logic                    HRESP_slv_o;
   logic [DATA_WIDTH-1:0]   HRDATA_slv_o;
   logic [ADDR_WIDTH-1:0]   ADDR_slv_o;
   logic                    WRITE_slv_o;
   logic [DATA_WIDTH-1:0]   WDATA_slv_o;
   logic [DATA_WIDTH/8-1:0] BE_slv_o;
   logic                    REQ_slv_o;
   logic                    GRANT_slv_i;
   logic [DATA_WIDTH-1:0]   RDATA_slv_i;

   modport slave (
      input  HSEL_slv_i, HADDR_slv_i, HSIZE_slv_i, HBURST_slv_i, HTRANS_slv_i,
             HWRITE_slv_i, HREADY_slv_i, HWDATA_slv_i, GRANT_slv_i, RDATA_slv_i,
      output HREADY_slv_o, HRESP_slv_o, HRDATA_slv_o, ADDR_slv_o, WRITE_slv_o,
             WDATA_slv_o, BE_slv_o, REQ_slv_o
   );

   modport master (
      output HSEL_slv_i, HADDR_slv_i, HSIZE_slv_i, HBURST_slv_i, HTRANS_slv_i,
             HWRITE_slv_i, HREADY_slv_i, HWDATA_slv_i, GRANT_slv_i, RDATA_slv_i,
      input  HREADY_slv_o, HRESP_slv_o, HRDATA_slv_o, ADDR_slv_o, WRITE_slv_o,
             WDATA_slv_o, BE_slv_o, REQ_slv_o
   );
endinterface

// File: rtl/ahb_lite_mem_bridge_xfer_check.sv
// Combinational address-phase checker: window decode, size and alignment
// errors, window-relative offset and byte-lane enables.
module ahb_lite_xfer_check
   import ahb_lite_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int unsigned           MEM_BYTES  = 4096
) (
   input  logic [ADDR_WIDTH-1:0]   haddr_i,
   input  logic [2:0]              hsize_i,
   output xfer_err_e               err_o,
   output logic [ADDR_WIDTH-1:0]   offset_o,
   output logic [DATA_WIDTH/8-1:0] be_o
);
   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int LANE_W = $clog2(NBYTES);
   localparam logic [2:0]          MAX_SIZE  = 3'(LANE_W);
   localparam logic [ADDR_WIDTH:0] WIN_BYTES = (ADDR_WIDTH+1)'(MEM_BYTES);

   logic [ADDR_WIDTH:0]   diff;
   logic                  in_window;
   logic [ADDR_WIDTH-1:0] align_mask;
   int                    lane;
   int                    nbytes_acc;

   // An address below the base borrows into the top bit, which pushes the
   // difference past any window size, so one compare covers both edges.
   assign diff       = {1'b0, haddr_i} - {1'b0, BASE_ADDR};
   assign in_window  = (diff < WIN_BYTES);
   assign offset_o   = diff[ADDR_WIDTH-1:0];
   assign align_mask = (ADDR_WIDTH'(1) << hsize_i) - ADDR_WIDTH'(1);

   // Classify the transfer; first failing rule wins.
   always_comb begin
      err_o = XERR_NONE;
      if (!in_window) begin
         err_o = XERR_RANGE;
      end else if (hsize_i > MAX_SIZE) begin
         err_o = XERR_SIZE;
      end else if (|(haddr_i & align_mask)) begin
         err_o = XERR_ALIGN;
      end
   end

   // Enable 2^HSIZE consecutive lanes starting at the addressed byte lane.
   always_comb begin
      lane       = int'(haddr_i & ADDR_WIDTH'(NBYTES - 1));
      nbytes_acc = 1 << hsize_i;
      be_o       = '0;
      for (int i = 0; i < NBYTES; i++) begin
         be_o[i] = (i >= lane) && (i < lane + nbytes_acc);
      end
   end

endmodule

// File: rtl/ahb_lite_mem_bridge.sv
// AHB-Lite slave that turns bus transfers into single-port memory req/grant
// cycles, with window/size/alignment checks and a grant timeout.
module ahb_lite_mem_bridge
   import ahb_lite_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int unsigned           MEM_BYTES      = 4096,
   parameter int unsigned           TIMEOUT_CYCLES = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   ahb_lite_mem_bridge_if.slave  bus
);
   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   bridge_state_e         state_q;
   logic [CNT_W-1:0]      tmo_q;
   logic [CNT_W-1:0]      tmo_d;
   logic                  hready_q;
   logic                  hresp_q;
   logic [DATA_WIDTH-1:0] hrdata_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [NBYTES-1:0]     be_q;
   logic                  req_q;

   xfer_err_e             chk_err;
   logic [ADDR_WIDTH-1:0] chk_offset;
   logic [NBYTES-1:0]     chk_be;
   logic                  accept;
   logic                  unused_hburst;

   // Burst type carries no information here: every beat brings its own address.
   assign unused_hburst = ^bus.HBURST_slv_i;

   ahb_lite_xfer_check #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .BASE_ADDR  (BASE_ADDR),
      .MEM_BYTES  (MEM_BYTES)
   ) u_check (
      .haddr_i  (bus.HADDR_slv_i),
      .hsize_i  (bus.HSIZE_slv_i),
      .err_o    (chk_err),
      .offset_o (chk_offset),
      .be_o     (chk_be)
   );

   assign accept = bus.HSEL_slv_i && bus.HREADY_slv_i &&
                   ((bus.HTRANS_slv_i == HTRANS_NONSEQ) || (bus.HTRANS_slv_i == HTRANS_SEQ));
   assign tmo_d  = tmo_q + CNT_W'(1);

   // Bridge FSM; every bus and memory output is a register updated here.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= ST_IDLE;
         tmo_q    <= '0;
         hready_q <= 1'b1;
         hresp_q  <= HRESP_OKAY;
         hrdata_q <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         be_q     <= '0;
         req_q    <= 1'b0;
      end else begin
         case (state_q)
            // Address phases are only taken while the bus sees us ready.
            ST_IDLE, ST_RESP, ST_ERR2: begin
               if (accept) begin
                  hready_q <= 1'b0;
                  if (chk_err != XERR_NONE) begin
                     hresp_q <= HRESP_ERROR;
                     state_q <= ST_ERR1;
                  end else begin
                     // Memory side ignores these while REQ is low, so they can
                     // be captured straight from the address phase.
                     hresp_q <= HRESP_OKAY;
                     addr_q  <= chk_offset;
                     be_q    <= chk_be;
                     write_q <= bus.HWRITE_slv_i;
                     if (bus.HWRITE_slv_i) begin
                        state_q <= ST_WDATA;
                     end else begin
                        req_q   <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= ST_MREQ;
                     end
                  end
               end else begin
                  hready_q <= 1'b1;
                  hresp_q  <= HRESP_OKAY;
                  state_q  <= ST_IDLE;
               end
            end
            ST_WDATA: begin
               wdata_q <= bus.HWDATA_slv_i;
               req_q   <= 1'b1;
               tmo_q   <= '0;
               state_q <= ST_MREQ;
            end
            // A grant in the same cycle as the timeout still completes OKAY.
            ST_MREQ: begin
               if (bus.GRANT_slv_i) begin
                  req_q    <= 1'b0;
                  hready_q <= 1'b1;
                  hresp_q  <= HRESP_OKAY;
                  if (!write_q) begin
                     hrdata_q <= bus.RDATA_slv_i;
                  end
                  state_q <= ST_RESP;
               end else if (TIMEOUT_CYCLES != 0) begin
                  tmo_q <= tmo_d;
                  if (tmo_d == TMO_LIMIT) begin
                     req_q   <= 1'b0;
                     hresp_q <= HRESP_ERROR;
                     state_q <= ST_ERR1;
                  end
               end
            end
            ST_ERR1: begin
               hready_q <= 1'b1;
               hresp_q  <= HRESP_ERROR;
               state_q  <= ST_ERR2;
            end
            default: begin
               req_q    <= 1'b0;
               hready_q <= 1'b1;
               hresp_q  <= HRESP_OKAY;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.HREADY_slv_o = hready_q;
   assign bus.HRESP_slv_o  = hresp_q;
   assign bus.HRDATA_slv_o = hrdata_q;
   assign bus.ADDR_slv_o   = addr_q;
   assign bus.WRITE_slv_o  = write_q;
   assign bus.WDATA_slv_o  = wdata_q;
   assign bus.BE_slv_o     = be_q;
   assign bus.REQ_slv_o    = req_q;

endmodule
